// File: rtl/qspi_read_cache.sv
// qspi_read_cache: direct-mapped one-word read cache in front of a QSPI controller.
// Define QSPI_CACHE_STATS_EN to build the hit/miss statistics counters.
module qspi_read_cache #(
  parameter int LINES = 8,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_addr,
  input  logic [3:0]  s_wstrb,
  input  logic [31:0] s_wdata,
  output logic [31:0] s_rdata,
  input  logic        s_cacheable,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        flush,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic        s_ready_q, s_ready_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] s_rdata_q, s_rdata_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [3:0]  m_wstrb_q, m_wstrb_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        fill_q, fill_d;
  logic        merge_q, merge_d;
  logic        pend_q, pend_d;

  logic [LINES-1:0] vld_q, vld_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [31:0]      data_q [LINES];

  logic [IDX_W-1:0] s_idx;
  logic [IDX_W-1:0] m_idx;
  logic [TAG_W-1:0] s_tag;
  logic [TAG_W-1:0] m_tag;
  logic             s_rd;
  logic             lookup_hit;
  logic             accept;
  logic             arr_we;
  logic [31:0]      merged;

  assign s_idx = s_addr[2+:IDX_W];
  assign s_tag = s_addr[31-:TAG_W];
  assign m_idx = m_addr_q[2+:IDX_W];
  assign m_tag = m_addr_q[31-:TAG_W];
  assign s_rd  = (s_wstrb == 4'b0000);

  // A same-cycle flush forces a miss so the request never sees stale lines.
  assign lookup_hit = s_cacheable && !flush
                   && vld_q[s_idx]
                   && (tag_q[s_idx] == s_tag);

  assign accept = (state_q == IDLE) && !pend_q && s_valid;

  assign arr_we = (state_q == MEM) && m_ready
               && (fill_q || merge_q);

  always_comb begin
    merged = data_q[m_idx];
    for (int b = 0; b < 4; b++) begin
      if (m_wstrb_q[b]) begin
        merged[8*b+:8] = m_wdata_q[8*b+:8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    s_ready_d = 1'b0;
    m_valid_d = m_valid_q;
    s_rdata_d = s_rdata_q;
    m_addr_d  = m_addr_q;
    m_wstrb_d = m_wstrb_q;
    m_wdata_d = m_wdata_q;
    fill_d    = fill_q;
    merge_d   = merge_q;
    pend_d    = pend_q;
    vld_d     = vld_q;
    unique case (state_q)
      IDLE: begin
        if (pend_q || flush) begin
          vld_d  = '0;
          pend_d = 1'b0;
        end
        if (accept) begin
          if (lookup_hit && s_rd) begin
            state_d   = RESP;
            s_ready_d = 1'b1;
            s_rdata_d = data_q[s_idx];
          end else begin
            state_d   = MEM;
            m_valid_d = 1'b1;
            m_addr_d  = s_addr;
            m_wstrb_d = s_wstrb;
            m_wdata_d = s_wdata;
            fill_d    = s_cacheable && s_rd;
            merge_d   = lookup_hit && !s_rd;
          end
        end
      end
      MEM: begin
        if (flush) begin
          pend_d = 1'b1;
        end
        if (m_ready) begin
          state_d   = RESP;
          m_valid_d = 1'b0;
          s_ready_d = 1'b1;
          s_rdata_d = (m_wstrb_q == 4'b0000) ? m_rdata : 32'd0;
          if (fill_q) begin
            vld_d[m_idx] = 1'b1;
          end
        end
      end
      RESP: begin
        if (flush) begin
          pend_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      s_rdata_q <= '0;
      m_addr_q  <= '0;
      m_wstrb_q <= '0;
      m_wdata_q <= '0;
      fill_q    <= 1'b0;
      merge_q   <= 1'b0;
      pend_q    <= 1'b0;
      vld_q     <= '0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      s_rdata_q <= s_rdata_d;
      m_addr_q  <= m_addr_d;
      m_wstrb_q <= m_wstrb_d;
      m_wdata_q <= m_wdata_d;
      fill_q    <= fill_d;
      merge_q   <= merge_d;
      pend_q    <= pend_d;
      vld_q     <= vld_d;
    end
  end

  // Tag/data need no reset; a reset cycle still blocks the write.
  always_ff @(posedge clk) begin
    if (rst_n && arr_we) begin
      if (fill_q) begin
        tag_q[m_idx]  <= m_tag;
        data_q[m_idx] <= m_rdata;
      end else begin
        data_q[m_idx] <= merged;
      end
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign s_rdata = s_rdata_q;
  assign m_addr  = m_addr_q;
  assign m_wstrb = m_wstrb_q;
  assign m_wdata = m_wdata_q;

`ifdef QSPI_CACHE_STATS_EN
  logic [15:0] hit_q, hit_d;
  logic [15:0] miss_q, miss_d;
  logic        flush_now;
  logic        hit_ev;
  logic        miss_ev;

  assign flush_now = (state_q == IDLE) && (pend_q || flush);
  assign hit_ev    = accept && lookup_hit && s_rd;
  assign miss_ev   = accept && s_cacheable && s_rd && !lookup_hit;

  always_comb begin
    hit_d  = flush_now ? 16'd0 : hit_q;
    miss_d = flush_now ? 16'd0 : miss_q;
    if (hit_ev && (hit_d != 16'hFFFF)) begin
      hit_d = hit_d + 16'd1;
    end
    if (miss_ev && (miss_d != 16'hFFFF)) begin
      miss_d = miss_d + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = 16'd0;
  assign miss_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_qspi_read_cache.sv
// tb_qspi_read_cache: directed and random requests against a cache/memory
// reference model; responses and memory transactions checked by scoreboards.
`timescale 1ns/1ps
module tb_qspi_read_cache;

  localparam int LINES = 8;
  localparam int IDX_W = 3;
`ifdef QSPI_CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_cacheable;
  logic        m_valid, m_ready;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        flush;
  logic [15:0] hit_cnt, miss_cnt;

  qspi_read_cache #(.LINES(LINES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_addr(s_addr), .s_wstrb(s_wstrb),
    .s_wdata(s_wdata), .s_rdata(s_rdata),
    .s_cacheable(s_cacheable),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_addr(m_addr), .m_wstrb(m_wstrb),
    .m_wdata(m_wdata), .m_rdata(m_rdata),
    .flush(flush),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory contents; untouched words have a fixed address-derived value.
  logic [31:0] mem [int unsigned];

  function automatic logic [31:0] memrd(input int unsigned w);
    if (mem.exists(w)) return mem[w];
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o,
                                         input logic [3:0] s,
                                         input logic [31:0] d);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b+:8] = d[8*b+:8];
    return r;
  endfunction

  // Reference cache contents and statistics.
  bit          mv [LINES];
  int unsigned mt [LINES];
  logic [31:0] md [LINES];
  int          hits = 0;
  int          misses = 0;

  task automatic mclear();
    for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
    hits = 0;
    misses = 0;
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } mtx_t;

  logic [31:0] sq [$];
  mtx_t        mq [$];
  int          delay_fix = -1;
  bit          noresp = 1'b0;

  // Response scoreboard monitor.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && s_ready) begin
      chk("resp_expected", {31'd0, sq.size() != 0}, 32'd1);
      if (sq.size() != 0) begin
        e = sq.pop_front();
        chk("s_rdata", s_rdata, e);
      end
    end
  end

  // Memory responder and memory-side transaction checker.
  initial begin : responder
    bit   busy;
    int   cnt;
    mtx_t cur;
    mtx_t e;
    busy = 1'b0;
    cnt = 0;
    cur = '0;
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (noresp || !rst_n) begin
        busy = 1'b0;
        m_ready = 1'b0;
      end else if (m_ready) begin
        m_ready = 1'b0;
        busy = 1'b0;
        chk("m_valid_drop", {31'd0, m_valid}, 32'd0);
      end else if (busy || m_valid) begin
        if (!busy) begin
          busy = 1'b1;
          cnt = (delay_fix >= 0) ? delay_fix : $urandom_range(0, 4);
          cur.a = m_addr;
          cur.s = m_wstrb;
          cur.d = m_wdata;
          chk("mem_txn_expected", {31'd0, mq.size() != 0}, 32'd1);
          if (mq.size() != 0) begin
            e = mq.pop_front();
            chk("m_addr", m_addr, e.a);
            chk("m_wstrb", {28'd0, m_wstrb}, {28'd0, e.s});
            chk("m_wdata", m_wdata, e.d);
          end
        end else begin
          chk("m_valid_held", {31'd0, m_valid}, 32'd1);
          chk("m_addr_stable", m_addr, cur.a);
          chk("m_wdata_stable", m_wdata, cur.d);
        end
        if (cnt == 0) begin
          m_ready = 1'b1;
          if (cur.s == 4'd0) begin
            m_rdata = memrd(cur.a >> 2);
          end else begin
            m_rdata = $urandom;
            mem[cur.a >> 2] = bmerge(memrd(cur.a >> 2), cur.s, cur.d);
          end
        end else begin
          cnt--;
          m_rdata = $urandom;
        end
      end
    end
  end

  // fl: 0 none, 1 flush with the request, 2 flush while in MEM.
  task automatic do_req(input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input bit c, input int fl);
    int          idx;
    int          n;
    int unsigned tg;
    bit          rd;
    bit          hit;
    bit          f2;
    mtx_t        t;
    @(negedge clk);
    @(negedge clk);
    chk("hit_cnt", {16'd0, hit_cnt}, STATS ? hits : 0);
    chk("miss_cnt", {16'd0, miss_cnt}, STATS ? misses : 0);
    idx = int'((a >> 2) % LINES);
    tg = a >> (2 + IDX_W);
    rd = (s == 4'd0);
    if (fl == 1) mclear();
    hit = c && mv[idx] && (mt[idx] == tg);
    if (rd && hit) begin
      sq.push_back(md[idx]);
      if (hits < 65535) hits++;
    end else begin
      t.a = a;
      t.s = s;
      t.d = d;
      mq.push_back(t);
      if (rd) begin
        sq.push_back(memrd(a >> 2));
        if (c) begin
          if (misses < 65535) misses++;
          mv[idx] = 1'b1;
          mt[idx] = tg;
          md[idx] = memrd(a >> 2);
        end
      end else begin
        sq.push_back(32'd0);
        if (hit) md[idx] = bmerge(md[idx], s, d);
      end
    end
    f2 = (fl == 2) && !(rd && hit);
    s_addr = a;
    s_wstrb = s;
    s_wdata = d;
    s_cacheable = c;
    s_valid = 1'b1;
    flush = (fl == 1);
    @(negedge clk);
    flush = 1'b0;
    n = 1;
    if (f2) flush = 1'b1;
    while (!s_ready && n < 300) begin
      @(negedge clk);
      flush = 1'b0;
      n++;
    end
    flush = 1'b0;
    chk("req_done", {31'd0, s_ready}, 32'd1);
    if (rd && hit) chk("hit_latency", n, 32'd1);
    s_valid = 1'b0;
    s_wstrb = '0;
    if (f2) mclear();
  endtask

  task automatic reset_mid_mem();
    int n;
    @(negedge clk);
    @(negedge clk);
    noresp = 1'b1;
    s_addr = 32'h40;
    s_wstrb = '0;
    s_cacheable = 1'b0;
    s_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mem_entered", {31'd0, m_valid}, 32'd1);
    rst_n = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_mid_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_mid_m_addr", m_addr, 32'd0);
    mclear();
    noresp = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [31:0] a;
    logic [3:0]  s;
    int          r;
    s_valid = 1'b0;
    s_addr = '0;
    s_wstrb = '0;
    s_wdata = '0;
    s_cacheable = 1'b0;
    flush = 1'b0;
    mclear();
    mem[32'h40 >> 2] = 32'hDEAD_BEEF;
    mem[32'h60 >> 2] = 32'h6060_A5A5;
    mem[32'h80 >> 2] = 32'h8080_1357;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_s_rdata", s_rdata, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wstrb", {28'd0, m_wstrb}, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_hit_cnt", {16'd0, hit_cnt}, 32'd0);
    chk("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    rst_n = 1'b1;

    delay_fix = 5;
    do_req(32'h40, 4'd0, 32'd0, 1'b1, 0);
    delay_fix = -1;
    do_req(32'h40, 4'd0, 32'd0, 1'b1, 0);

    do_req(32'h40, 4'd0, 32'd0, 1'b1, 1);
    do_req(32'h60, 4'd0, 32'd0, 1'b1, 0);
    do_req(32'h40, 4'd0, 32'd0, 1'b1, 0);

    do_req(32'h40, 4'b0011, 32'h0000_1234, 1'b1, 0);
    do_req(32'h40, 4'd0, 32'd0, 1'b1, 0);

    do_req(32'h80, 4'd0, 32'd0, 1'b1, 2);
    do_req(32'h80, 4'd0, 32'd0, 1'b1, 0);

    do_req(32'h40, 4'd0, 32'd0, 1'b0, 0);
    do_req(32'h40, 4'd0, 32'd0, 1'b0, 0);
    do_req(32'h40, 4'd0, 32'd0, 1'b1, 0);

    reset_mid_mem();
    do_req(32'h40, 4'd0, 32'd0, 1'b1, 0);
    do_req(32'h40, 4'd0, 32'd0, 1'b1, 0);

    repeat (400) begin
      a = ({30'd0, 2'($urandom_range(0, 3))} << 5)
        | ({29'd0, 3'($urandom_range(0, 7))} << 2)
        | {30'd0, 2'($urandom_range(0, 3))};
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      r = $urandom_range(0, 19);
      do_req(a, s, $urandom, $urandom_range(0, 4) != 0,
             (r == 0) ? 1 : ((r == 1) ? 2 : 0));
    end

    repeat (4) @(negedge clk);
    chk("final_hit_cnt", {16'd0, hit_cnt}, STATS ? hits : 0);
    chk("final_miss_cnt", {16'd0, miss_cnt}, STATS ? misses : 0);
    chk("mem_q_empty", mq.size(), 32'd0);
    chk("resp_q_empty", sq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qspi_read_cache.md
QSPI_READ_CACHE -- requirements
Module: qspi_read_cache

Interface
REQ-001 SHALL have parameter LINES, default 8, number of one-word direct-mapped lines (power of two, 2..64).
REQ-002 SHALL have parameter IDX_W, default $clog2(LINES), index width.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports s_valid in 1, s_ready out 1, s_addr in 32 (byte address), s_wstrb in 4, s_wdata in 32, s_rdata out 32: CPU-side request.
REQ-006 SHALL have port s_cacheable  input  1  request may allocate/hit (flash/PSRAM region); 0 = pass-through.
REQ-007 SHALL have ports m_valid out 1, m_ready in 1, m_addr out 32, m_wstrb out 4, m_wdata out 32, m_rdata in 32: memory-controller side.
REQ-008 SHALL have port flush  input  1  one-cycle pulse, invalidate all lines.
REQ-009 SHALL have ports hit_cnt out 16, miss_cnt out 16: statistics (see Configuration).

Function
REQ-010 SHALL decode index = s_addr[2+IDX_W-1:2], tag = s_addr[31:2+IDX_W]; s_addr[1:0] ignored.
REQ-011 SHALL use FSM states IDLE, MEM, RESP.
REQ-012 IDLE: s_valid && s_cacheable && s_wstrb==0 && line valid && tag match (hit) -> RESP with s_rdata = stored word; hit latency 1 cycle (s_ready high the cycle after s_valid sampled).
REQ-013 IDLE: any other s_valid -> MEM; m_addr/m_wstrb/m_wdata registered from s_* on entry.
REQ-014 MEM: m_valid held high until m_ready; m_addr/m_wstrb/m_wdata stable throughout; on m_ready -> RESP, s_rdata captured from m_rdata (writes: 0).
REQ-015 Read miss with s_cacheable=1: on m_ready, line written with m_rdata, tag stored, valid set.
REQ-016 Write with s_cacheable=1 and hit: on m_ready, stored word byte-merged per m_wstrb (write-through); write miss SHALL NOT allocate.
REQ-017 s_cacheable=0: memory access only, no array read/update.
REQ-018 RESP: s_ready high exactly one cycle, -> IDLE; s_valid ignored in RESP (master drops it after ready).
REQ-019 s_ready, m_valid SHALL be registered outputs; s_rdata held stable while s_ready high.
REQ-020 flush in IDLE: all valid bits cleared next cycle; a request sampled in the same cycle SHALL be treated as miss.
REQ-021 flush in MEM/RESP: latched pending, applied on return to IDLE, after any fill of the in-flight access; no request accepted that cycle.
REQ-022 Memory-side transaction SHALL not be abandoned except by reset.

Reset
REQ-023 rst_n low: state IDLE, s_ready=0, m_valid=0, s_rdata=0, m_addr/m_wstrb/m_wdata=0, all valid bits 0, pending flush 0, counters 0.
REQ-024 Reset mid-MEM SHALL drop m_valid next cycle with no array update; tag/data storage need not reset.

Configuration
REQ-025 Macro QSPI_CACHE_STATS_EN defined: hit_cnt increments on each cacheable read hit, miss_cnt on each cacheable read miss, both saturating at 16'hFFFF, cleared by reset and by flush.
REQ-026 Macro undefined: hit_cnt, miss_cnt tied to 0, no counter logic.

Verification
REQ-027 Read 0x0000_0040 cacheable, memory returns 0xDEADBEEF after 5 cycles -> one m_valid transaction, s_rdata=0xDEADBEEF; repeat read -> no m_valid, s_ready 1 cycle after s_valid, same data.
REQ-028 Conflict: read 0x40 then 0x60 (LINES=8, same index) then 0x40 -> three memory reads; miss_cnt=3, hit_cnt=0 with stats enabled.
REQ-029 Write 0x40 wstrb=4'b0011 wdata=0x0000_1234 after cached 0xDEADBEEF -> memory write forwarded, subsequent read hits with 0xDEAD1234.
REQ-030 flush pulsed during MEM of read 0x80 -> fill completes, s_rdata correct, next read 0x80 misses.
REQ-031 s_cacheable=0 read 0x40 twice -> two memory reads, array unchanged, counters unchanged.
REQ-032 rst_n low for 1 cycle during MEM -> m_valid 0 next cycle, s_ready never asserted, following read 0x40 misses.
